// File: rtl/capture_trigger_ctrl.sv
// Capture trigger controller: arms on a synchronized rising edge of I_arm,
// accepts one trigger, waits a programmable delay, then holds the capture
// enable for a programmable window (or until FIFO full / disarm).
module capture_trigger_ctrl #(
  parameter int unsigned pDELAY_WIDTH  = 20,
  parameter int unsigned pWINDOW_WIDTH = 24
) (
  input  logic                     fe_clk,
  input  logic                     reset_n,
  input  logic                     I_arm,
  input  logic                     I_trigger,
  input  logic [pDELAY_WIDTH-1:0]  I_trigger_delay,
  input  logic [pWINDOW_WIDTH-1:0] I_capture_window,
  input  logic                     I_fifo_full,
  output logic                     O_capture_enable,
  output logic                     O_armed,
  output logic                     O_triggered,
  output logic                     O_done,
  output logic                     O_fifo_overflow_blocked,
  output logic [2:0]               O_state
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_DELAY   = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  localparam logic [pDELAY_WIDTH-1:0]  DLY_ONE = pDELAY_WIDTH'(1);
  localparam logic [pWINDOW_WIDTH-1:0] WIN_ONE = pWINDOW_WIDTH'(1);

  state_t                     state_q, state_d;
  logic                       arm_s1_q, arm_s1_d;
  logic                       arm_s2_q, arm_s2_d;
  logic                       arm_d_q, arm_d_d;
  logic [pDELAY_WIDTH-1:0]    dly_cnt_q, dly_cnt_d;
  logic [pWINDOW_WIDTH-1:0]   win_cnt_q, win_cnt_d;
  logic                       trig_q, trig_d;
  logic                       ovf_q, ovf_d;
  logic                       arm_rise;
  logic                       arm_fall;

  // Two-flop synchronizer for I_arm plus a delayed copy for edge detection.
  always_comb begin
    arm_s1_d = I_arm;
    arm_s2_d = arm_s1_q;
    arm_d_d  = arm_s2_q;
    arm_rise = arm_s2_q & ~arm_d_q;
    arm_fall = ~arm_s2_q & arm_d_q;
  end

  // Next-state, counter and sticky-flag logic; disarm overrides every state.
  always_comb begin
    state_d   = state_q;
    dly_cnt_d = dly_cnt_q;
    win_cnt_d = win_cnt_q;
    trig_d    = trig_q;
    ovf_d     = ovf_q;
    if (arm_fall) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arm_rise) begin
            state_d = ST_ARMED;
            trig_d  = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        ST_ARMED: begin
          if (I_trigger) begin
            trig_d    = 1'b1;
            dly_cnt_d = I_trigger_delay;
            win_cnt_d = I_capture_window;
            state_d   = (I_trigger_delay != '0) ? ST_DELAY : ST_CAPTURE;
          end
        end
        ST_DELAY: begin
          // Saturating countdown: the edge that sees a count of 1 starts capture.
          if (dly_cnt_q != '0) dly_cnt_d = dly_cnt_q - DLY_ONE;
          if (dly_cnt_q <= DLY_ONE) state_d = ST_CAPTURE;
        end
        ST_CAPTURE: begin
          // A window count of zero means unbounded and is never decremented.
          if (win_cnt_q != '0) win_cnt_d = win_cnt_q - WIN_ONE;
          if (I_fifo_full) begin
            state_d = ST_DONE;
            ovf_d   = 1'b1;
          end else if (win_cnt_q == WIN_ONE) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (arm_rise) begin
            state_d = ST_ARMED;
            trig_d  = 1'b0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State, synchronizer, counters and sticky flags; async active-low reset.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      arm_s1_q  <= 1'b0;
      arm_s2_q  <= 1'b0;
      arm_d_q   <= 1'b0;
      dly_cnt_q <= '0;
      win_cnt_q <= '0;
      trig_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_s1_q  <= arm_s1_d;
      arm_s2_q  <= arm_s2_d;
      arm_d_q   <= arm_d_d;
      dly_cnt_q <= dly_cnt_d;
      win_cnt_q <= win_cnt_d;
      trig_q    <= trig_d;
      ovf_q     <= ovf_d;
    end
  end

  // Outputs are pure decodes of registered state and sticky flops.
  assign O_capture_enable        = (state_q == ST_CAPTURE);
  assign O_armed                 = (state_q == ST_ARMED);
  assign O_done                  = (state_q == ST_DONE);
  assign O_triggered             = trig_q;
  assign O_fifo_overflow_blocked = ovf_q;
  assign O_state                 = state_q;

endmodule
